// File: rtl/mmu_sram_unit.sv
// mmu_sram_unit
//   Burst-capable SRAM bus slave that sits directly behind the MMU arbiter.
//   It services SINGLE, INCR4/8 and WRAP4/8 transfers of byte, half or word
//   size against an internal array of DEPTH 32-bit words. It occupies byte
//   addresses 0 .. DEPTH*4-1.
//
// Ports
//   CLK         clock, rising edge
//   RSTN        synchronous reset, active low
//   SELX        slave select from the arbiter address decode
//   ADDR        byte address, sampled on NONSEQ only
//   WRITE_DATA  write data, sampled on every accepted write beat
//   READ_DATA   registered word read by the last accepted read beat
//   WRITE       1 = write, 0 = read, latched on NONSEQ
//   SIZE        0 byte, 1 half, 2 word
//   BURST       0 SINGLE, 1 INCR4, 2 INCR8, 3 WRAP4, 4 WRAP8
//   TRANS       0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
//   READYOUT    0 while a burst is continuing
//   RESP        1 for the single error cycle
//
// state    | meaning
// ST_IDLE  | ready; a NONSEQ request is checked and beat 0 executed
// ST_BURST | burst in progress; SEQ beats run from next_addr
// ST_ERR   | one-cycle error response, then back to ST_IDLE
module mmu_sram_unit #(
   parameter int DEPTH = 64
) (
   input  logic        CLK,
   input  logic        RSTN,
   input  logic        SELX,
   input  logic [31:0] ADDR,
   input  logic [31:0] WRITE_DATA,
   output logic [31:0] READ_DATA,
   input  logic        WRITE,
   input  logic [2:0]  SIZE,
   input  logic [2:0]  BURST,
   input  logic [2:0]  TRANS,
   output logic        READYOUT,
   output logic        RESP
);

   localparam int          IW    = $clog2(DEPTH);
   localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

   localparam logic [2:0] T_IDLE   = 3'd0;
   localparam logic [2:0] T_BUSY   = 3'd1;
   localparam logic [2:0] T_NONSEQ = 3'd2;
   localparam logic [2:0] T_SEQ    = 3'd3;

   typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_ERR} state_t;

   state_t      state, state_nxt;
   logic        write_q, write_nxt;
   logic [1:0]  size_q, size_nxt;
   logic [2:0]  burst_q, burst_nxt;
   logic [3:0]  total_q, total_nxt;
   logic [3:0]  beat_q, beat_nxt;
   logic [31:0] next_addr, next_addr_nxt;

   logic        accept;
   logic        beat_en;
   logic        beat_wr;
   logic [IW-1:0] beat_idx;
   logic [1:0]  beat_lane;
   logic [1:0]  beat_size;
   logic [3:0]  byte_en;

   logic [31:0] mem [DEPTH];

   function automatic logic [3:0] total_of(input logic [2:0] b);
      case (b)
         3'd1, 3'd3: total_of = 4'd4;
         3'd2, 3'd4: total_of = 4'd8;
         default:    total_of = 4'd1;
      endcase
   endfunction

   function automatic logic [31:0] addr_step(input logic [31:0] a,
                                             input logic [1:0]  sz,
                                             input logic [2:0]  b);
      logic [31:0] inc;
      logic [31:0] span;
      inc  = 32'd1 << sz;
      span = 32'(total_of(b)) * inc;
      if (b == 3'd3 || b == 3'd4)
         addr_step = (a & ~(span - 32'd1)) | ((a + inc) & (span - 32'd1));
      else
         addr_step = a + inc;
   endfunction

   function automatic logic req_legal(input logic [31:0] a,
                                      input logic [2:0]  sz,
                                      input logic [2:0]  b);
      req_legal = (sz <= 3'd2) && (b <= 3'd4) && (a < LIMIT)
               && !(sz == 3'd1 && a[0])
               && !(sz == 3'd2 && a[1:0] != 2'b00);
   endfunction

   always_comb begin
      state_nxt     = state;
      write_nxt     = write_q;
      size_nxt      = size_q;
      burst_nxt     = burst_q;
      total_nxt     = total_q;
      beat_nxt      = beat_q;
      next_addr_nxt = next_addr;
      accept        = 1'b0;
      beat_en       = 1'b0;
      beat_wr       = write_q;
      beat_idx      = next_addr[IW+1:2];
      beat_lane     = next_addr[1:0];
      beat_size     = size_q;

      case (state)
         ST_IDLE: begin
            if (SELX && TRANS == T_NONSEQ) accept = 1'b1;
         end
         ST_BURST: begin
            if (!SELX || TRANS == T_IDLE) begin
               state_nxt = ST_IDLE;
            end else if (TRANS == T_NONSEQ) begin
               accept = 1'b1;
            end else if (TRANS == T_SEQ) begin
               if (next_addr >= LIMIT) begin
                  // INCR burst ran off the end of the array
                  state_nxt = ST_ERR;
               end else begin
                  beat_en       = 1'b1;
                  beat_nxt      = beat_q + 4'd1;
                  next_addr_nxt = addr_step(next_addr, size_q, burst_q);
                  if (beat_q + 4'd1 == total_q) state_nxt = ST_IDLE;
               end
            end
            // T_BUSY: hold everything
         end
         ST_ERR: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      // a NONSEQ in IDLE or mid-burst starts a fresh transfer this edge
      if (accept) begin
         if (!req_legal(ADDR, SIZE, BURST)) begin
            state_nxt = ST_ERR;
         end else begin
            beat_en       = 1'b1;
            beat_wr       = WRITE;
            beat_idx      = ADDR[IW+1:2];
            beat_lane     = ADDR[1:0];
            beat_size     = SIZE[1:0];
            write_nxt     = WRITE;
            size_nxt      = SIZE[1:0];
            burst_nxt     = BURST;
            total_nxt     = total_of(BURST);
            beat_nxt      = 4'd1;
            next_addr_nxt = addr_step(ADDR, SIZE[1:0], BURST);
            state_nxt     = (total_of(BURST) == 4'd1) ? ST_IDLE : ST_BURST;
         end
      end
   end

   always_comb begin
      case (beat_size)
         2'd0:    byte_en = 4'b0001 << beat_lane;
         2'd1:    byte_en = beat_lane[1] ? 4'b1100 : 4'b0011;
         default: byte_en = 4'b1111;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state     <= ST_IDLE;
         write_q   <= 1'b0;
         size_q    <= 2'd0;
         burst_q   <= 3'd0;
         total_q   <= 4'd0;
         beat_q    <= 4'd0;
         next_addr <= 32'd0;
         READ_DATA <= 32'd0;
      end else begin
         state     <= state_nxt;
         write_q   <= write_nxt;
         size_q    <= size_nxt;
         burst_q   <= burst_nxt;
         total_q   <= total_nxt;
         beat_q    <= beat_nxt;
         next_addr <= next_addr_nxt;
         if (beat_en && !beat_wr) READ_DATA <= mem[beat_idx];
      end
   end

   // array is not reset, but a reset edge suppresses any pending write
   always_ff @(posedge CLK) begin
      if (RSTN && beat_en && beat_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) mem[beat_idx][8*i +: 8] <= WRITE_DATA[8*i +: 8];
         end
      end
   end

   assign READYOUT = (state != ST_BURST);
   assign RESP     = (state == ST_ERR);

endmodule

// File: tb/tb_mmu_sram_unit.sv
// Testbench for mmu_sram_unit: transaction-level model plus directed vectors.
module tb_mmu_sram_unit;

   localparam int          DEPTH = 64;
   localparam logic [31:0] LIMIT = 32'(DEPTH * 4);
   localparam logic [2:0]  T_IDLE = 3'd0, T_BUSY = 3'd1, T_NONSEQ = 3'd2, T_SEQ = 3'd3;
   localparam logic [2:0]  B_SINGLE = 3'd0, B_INCR4 = 3'd1, B_INCR8 = 3'd2,
                           B_WRAP4 = 3'd3, B_WRAP8 = 3'd4;
   localparam logic [2:0]  S_BYTE = 3'd0, S_HALF = 3'd1, S_WORD = 3'd2;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        selx = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic [31:0] rdata;
   logic        write = 1'b0;
   logic [2:0]  size = 3'd0;
   logic [2:0]  burst = 3'd0;
   logic [2:0]  trans = 3'd0;
   logic        readyout;
   logic        resp;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   mmu_sram_unit #(.DEPTH(DEPTH)) dut (
      .CLK(clk), .RSTN(rstn), .SELX(selx), .ADDR(addr), .WRITE_DATA(wdata),
      .READ_DATA(rdata), .WRITE(write), .SIZE(size), .BURST(burst),
      .TRANS(trans), .READYOUT(readyout), .RESP(resp)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pat(input int i);
      return (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
   endfunction

   // ---------------- behavioural model ----------------
   // mode 0 = ready, 1 = burst in progress, 2 = error cycle
   int          m_mode = 0;
   logic [31:0] m_rd = 32'd0;
   logic [31:0] mm [DEPTH];
   logic [31:0] pend [$];
   bit          m_wr;
   int          m_sz;

   initial for (int i = 0; i < DEPTH; i++) mm[i] = 32'd0;

   task automatic m_beat(input logic [31:0] a, input bit w, input int sz, input logic [31:0] wd);
      int wi;
      wi = int'(a / 4);
      if (w) begin
         for (int l = 0; l < 4; l++) begin
            if (sz == 2 || (sz == 1 && (l / 2) == int'(a[1])) || (sz == 0 && l == int'(a[1:0])))
               mm[wi][8*l +: 8] = wd[8*l +: 8];
         end
      end else begin
         m_rd = mm[wi];
      end
   endtask

   task automatic m_accept();
      int tot, inc, span;
      logic [31:0] base, a0;
      bit ok;
      pend.delete();
      ok = (size <= 2) && (burst <= 4) && (addr < LIMIT)
         && !(size == 1 && addr % 2 != 0) && !(size == 2 && addr % 4 != 0);
      if (!ok) begin
         m_mode = 2;
         return;
      end
      tot  = (burst == B_SINGLE) ? 1 : (burst == B_INCR4 || burst == B_WRAP4) ? 4 : 8;
      inc  = 1 << size;
      span = tot * inc;
      base = addr - (addr % 32'(span));
      for (int i = 0; i < tot; i++) begin
         if (burst == B_WRAP4 || burst == B_WRAP8)
            a0 = base + ((addr - base + 32'(i * inc)) % 32'(span));
         else
            a0 = addr + 32'(i * inc);
         pend.push_back(a0);
      end
      m_wr = write;
      m_sz = int'(size);
      a0 = pend.pop_front();
      m_beat(a0, m_wr, m_sz, wdata);
      m_mode = (pend.size() > 0) ? 1 : 0;
   endtask

   always @(posedge clk) begin
      logic [31:0] a;
      if (!rstn) begin
         m_mode = 0;
         m_rd   = 32'd0;
         pend.delete();
      end else if (m_mode == 2) begin
         m_mode = 0;
      end else if (m_mode == 1) begin
         if (!selx || trans == T_IDLE) begin
            m_mode = 0;
            pend.delete();
         end else if (trans == T_NONSEQ) begin
            m_accept();
         end else if (trans == T_SEQ) begin
            a = pend.pop_front();
            if (a >= LIMIT) begin
               m_mode = 2;
               pend.delete();
            end else begin
               m_beat(a, m_wr, m_sz, wdata);
               if (pend.size() == 0) m_mode = 0;
            end
         end
      end else if (selx && trans == T_NONSEQ) begin
         m_accept();
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("readyout", 32'(readyout), 32'(m_mode != 1));
         chk("resp", 32'(resp), 32'(m_mode == 2));
         chk("read_data", rdata, m_rd);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input bit s, input logic [2:0] tr, input logic [31:0] a, input bit w,
                      input logic [2:0] sz, input logic [2:0] b, input logic [31:0] wd);
      selx = s; trans = tr; addr = a; write = w; size = sz; burst = b; wdata = wd;
      cyc();
   endtask

   task automatic idle_cyc();
      drv(1'b0, T_IDLE, 32'd0, 1'b0, S_BYTE, B_SINGLE, 32'd0);
   endtask

   initial begin
      // reset
      rstn = 1'b0;
      cyc();
      chk_en = 1'b1;
      cyc();
      rstn = 1'b1;
      chk("rst_readyout", 32'(readyout), 32'd1);
      chk("rst_resp", 32'(resp), 32'd0);
      chk("rst_read_data", rdata, 32'd0);
      chk("pat_pin", pat(14), 32'h5454_0E0E);

      // preload whole array with INCR8 word writes
      for (int k = 0; k < 8; k++) begin
         drv(1, T_NONSEQ, 32'(k * 32), 1, S_WORD, B_INCR8, pat(k * 8));
         for (int j = 1; j < 8; j++) drv(1, T_SEQ, 32'd0, 1, S_WORD, B_INCR8, pat(k * 8 + j));
      end
      idle_cyc();

      // single word write/read
      drv(1, T_NONSEQ, 32'h10, 1, S_WORD, B_SINGLE, 32'hDEAD_BEEF);
      drv(1, T_NONSEQ, 32'h10, 0, S_WORD, B_SINGLE, 32'd0);
      chk("single_rd", rdata, 32'hDEAD_BEEF);
      chk("single_rdy", 32'(readyout), 32'd1);
      chk("model_pin_single", m_rd, 32'hDEAD_BEEF);
      idle_cyc();

      // INCR4 write 1..4 then INCR4 read
      drv(1, T_NONSEQ, 32'h20, 1, S_WORD, B_INCR4, 32'd1);
      for (int j = 2; j <= 4; j++) drv(1, T_SEQ, 32'd0, 1, S_WORD, B_INCR4, 32'(j));
      drv(1, T_NONSEQ, 32'h20, 0, S_WORD, B_INCR4, 32'd0);
      chk("incr4_rd0", rdata, 32'd1);
      chk("incr4_rdy0", 32'(readyout), 32'd0);
      for (int j = 2; j <= 4; j++) begin
         drv(1, T_SEQ, 32'd0, 0, S_WORD, B_INCR4, 32'd0);
         chk("incr4_rd", rdata, 32'(j));
         chk("incr4_rdy", 32'(readyout), (j == 4) ? 32'd1 : 32'd0);
      end
      idle_cyc();

      // WRAP4 read at 0x38 -> 0x38,0x3C,0x30,0x34
      drv(1, T_NONSEQ, 32'h38, 0, S_WORD, B_WRAP4, 32'd0);
      chk("wrap4_0", rdata, 32'h5454_0E0E);
      drv(1, T_SEQ, 32'd0, 0, S_WORD, B_WRAP4, 32'd0);
      chk("wrap4_1", rdata, 32'h5555_0F0F);
      drv(1, T_SEQ, 32'd0, 0, S_WORD, B_WRAP4, 32'd0);
      chk("wrap4_2", rdata, 32'h5656_0C0C);
      drv(1, T_SEQ, 32'd0, 0, S_WORD, B_WRAP4, 32'd0);
      chk("wrap4_3", rdata, 32'h5757_0D0D);
      idle_cyc();

      // byte and half writes, read back as words
      drv(1, T_NONSEQ, 32'h41, 1, S_BYTE, B_SINGLE, 32'h1122_AA33);
      drv(1, T_NONSEQ, 32'h46, 1, S_HALF, B_SINGLE, 32'hBEEF_1234);
      drv(1, T_NONSEQ, 32'h40, 0, S_WORD, B_SINGLE, 32'd0);
      chk("byte_lane1", rdata, 32'h4A4A_AA10);
      drv(1, T_NONSEQ, 32'h44, 0, S_WORD, B_SINGLE, 32'd0);
      chk("half_upper", rdata, 32'hBEEF_1111);
      idle_cyc();

      // WRAP8 half read at 0x0E
      drv(1, T_NONSEQ, 32'h0E, 0, S_HALF, B_WRAP8, 32'd0);
      for (int j = 1; j < 8; j++) drv(1, T_SEQ, 32'd0, 0, S_HALF, B_WRAP8, 32'd0);
      idle_cyc();

      // misaligned word write -> one error cycle, no write
      drv(1, T_NONSEQ, 32'h02, 1, S_WORD, B_SINGLE, 32'hFFFF_FFFF);
      chk("misalign_resp", 32'(resp), 32'd1);
      idle_cyc();
      chk("misalign_resp_clr", 32'(resp), 32'd0);
      drv(1, T_NONSEQ, 32'h00, 0, S_WORD, B_SINGLE, 32'd0);
      chk("misalign_nowrite", rdata, 32'h5A5A_0000);
      idle_cyc();

      // out-of-range, illegal size, illegal burst, misaligned half
      drv(1, T_NONSEQ, 32'h100, 0, S_WORD, B_SINGLE, 32'd0);
      chk("range_resp", 32'(resp), 32'd1);
      idle_cyc();
      drv(1, T_NONSEQ, 32'h10, 0, 3'd3, B_SINGLE, 32'd0);
      idle_cyc();
      drv(1, T_NONSEQ, 32'h10, 0, S_WORD, 3'd5, 32'd0);
      idle_cyc();
      drv(1, T_NONSEQ, 32'h11, 1, S_HALF, B_SINGLE, 32'd0);
      idle_cyc();

      // INCR8 read at 0xF0 runs off the end on the 5th beat
      drv(1, T_NONSEQ, 32'hF0, 0, S_WORD, B_INCR8, 32'd0);
      for (int j = 1; j < 4; j++) drv(1, T_SEQ, 32'd0, 0, S_WORD, B_INCR8, 32'd0);
      chk("incr8_last_ok", rdata, 32'h6565_3F3F);
      drv(1, T_SEQ, 32'd0, 0, S_WORD, B_INCR8, 32'd0);
      chk("incr8_err", 32'(resp), 32'd1);
      chk("incr8_err_rdy", 32'(readyout), 32'd1);
      drv(1, T_SEQ, 32'd0, 0, S_WORD, B_INCR8, 32'd0);
      chk("incr8_err_one", 32'(resp), 32'd0);
      idle_cyc();

      // TRANS=IDLE aborts INCR4 write after two beats
      drv(1, T_NONSEQ, 32'h80, 1, S_WORD, B_INCR4, 32'hA0A0_A0A0);
      drv(1, T_SEQ, 32'd0, 1, S_WORD, B_INCR4, 32'hA1A1_A1A1);
      drv(1, T_IDLE, 32'd0, 1, S_WORD, B_INCR4, 32'hA2A2_A2A2);
      chk("abort_rdy", 32'(readyout), 32'd1);
      drv(1, T_NONSEQ, 32'h80, 0, S_WORD, B_INCR4, 32'd0);
      for (int j = 1; j < 4; j++) drv(1, T_SEQ, 32'd0, 0, S_WORD, B_INCR4, 32'd0);
      chk("abort_w3_kept", rdata, 32'h7979_2323);
      idle_cyc();

      // BUSY holds, NONSEQ restarts mid-burst
      drv(1, T_NONSEQ, 32'h20, 0, S_WORD, B_INCR4, 32'd0);
      drv(1, T_BUSY, 32'd0, 0, S_WORD, B_INCR4, 32'd0);
      drv(1, T_BUSY, 32'd0, 0, S_WORD, B_INCR4, 32'd0);
      chk("busy_hold", rdata, 32'd1);
      drv(1, T_SEQ, 32'd0, 0, S_WORD, B_INCR4, 32'd0);
      chk("busy_resume", rdata, 32'd2);
      drv(1, T_NONSEQ, 32'h10, 0, S_WORD, B_SINGLE, 32'd0);
      chk("restart_rd", rdata, 32'hDEAD_BEEF);
      chk("restart_rdy", 32'(readyout), 32'd1);
      // SELX drop aborts
      drv(1, T_NONSEQ, 32'h30, 0, S_WORD, B_INCR4, 32'd0);
      drv(0, T_SEQ, 32'd0, 0, S_WORD, B_INCR4, 32'd0);
      idle_cyc();

      // reset mid-burst drops the write at the reset edge
      drv(1, T_NONSEQ, 32'hC0, 1, S_WORD, B_INCR4, 32'hC0C0_C0C0);
      drv(1, T_SEQ, 32'd0, 1, S_WORD, B_INCR4, 32'hC1C1_C1C1);
      rstn = 1'b0;
      drv(1, T_SEQ, 32'd0, 1, S_WORD, B_INCR4, 32'hC2C2_C2C2);
      rstn = 1'b1;
      chk("midrst_rdy", 32'(readyout), 32'd1);
      chk("midrst_rd", rdata, 32'd0);
      drv(1, T_SEQ, 32'd0, 1, S_WORD, B_INCR4, 32'hC3C3_C3C3);
      drv(1, T_NONSEQ, 32'hC0, 0, S_WORD, B_INCR4, 32'd0);
      chk("midrst_w0", rdata, 32'hC0C0_C0C0);
      for (int j = 1; j < 4; j++) drv(1, T_SEQ, 32'd0, 0, S_WORD, B_INCR4, 32'd0);
      chk("midrst_w3", rdata, 32'h6969_3333);
      idle_cyc();
      idle_cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mmu_sram_unit.md
Name: mmu_sram_unit

Overview:
- Burst-capable SRAM bus slave directly downstream of the MMU arbiter.
- Accepts the arbitrated bus (SELX, ADDR, WRITE, SIZE, BURST, TRANS, WRITE_DATA) and services single and burst transfers against an internal word array.
- Returns READ_DATA, READYOUT and RESP using the team bus protocol:
  - READYOUT=0, RESP=0: burst continuing.
  - READYOUT=1, RESP=0: done or ready.
  - RESP=1: error.
- Occupies byte addresses 0x000..(DEPTH*4-1); default window is 0x000-0x0FF.

Parameters:
DEPTH, 64, number of 32-bit words in the array; must be a power of two; address window is DEPTH*4 bytes.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RSTN  input  1  synchronous reset, active-low.
SELX  input  1  slave select from the arbiter address decode.
ADDR  input  32  byte address; sampled only on NONSEQ.
WRITE_DATA  input  32  write data; sampled on every accepted beat.
READ_DATA  output  32  full aligned word read by the last accepted beat.
WRITE  input  1  1=write, 0=read; latched on NONSEQ.
SIZE  input  3  0=byte, 1=half, 2=word; others are illegal.
BURST  input  3  0=SINGLE(1), 1=INCR4, 2=INCR8, 3=WRAP4, 4=WRAP8; others are illegal.
TRANS  input  3  0=IDLE, 1=BUSY, 2=NONSEQ, 3=SEQ.
READYOUT  output  1  see protocol above.
RESP  output  1  1=error response.

Behaviour:
- Reset (RSTN=0 at edge):
  - State goes to IDLE; READYOUT=1, RESP=0, READ_DATA=0; beat counter and next_addr are cleared.
  - Array contents are not reset.
  - Reset asserted mid-burst aborts the burst immediately; no further writes occur.
- States: IDLE, BURST, ERR.
- IDLE (READYOUT=1, RESP=0):
  - At an edge with SELX=1 and TRANS=NONSEQ, the request is checked.
  - Illegal SIZE/BURST, misalignment (half with ADDR[0]=1; word with ADDR[1:0]!=0), or ADDR >= DEPTH*4 -> ERR. No array access occurs.
  - Otherwise beat 0 executes at ADDR, and WRITE, SIZE and BURST are latched.
    - total = 1/4/8 per BURST.
    - beat = 1.
    - next_addr = next(ADDR).
  - If total=1, stay in IDLE (READYOUT=1).
  - Otherwise go to BURST (READYOUT=0).
- Beat execution:
  - Write: byte lanes are updated little-endian.
    - Byte: lane ADDR[1:0].
    - Half: lanes {ADDR[1],0} and {ADDR[1],1}.
    - Word: all lanes.
    - Data comes from the corresponding lanes of WRITE_DATA.
    - A read-after-write to the same word on the next beat returns the new value.
  - Read: READ_DATA <= mem[addr>>2], registered; valid from the cycle after the accepting edge.
  - During writes, READ_DATA holds its previous value.
- Address generation, with inc = 1<<SIZE:
  - INCR: next = addr + inc.
  - WRAP: span = total*inc; next = (addr & ~(span-1)) | ((addr+inc) & (span-1)).
- BURST (READYOUT=0, RESP=0):
  - TRANS=SEQ: execute the beat at next_addr; ADDR is ignored; beat++.
    - If the SEQ beat address is >= DEPTH*4 (INCR crossing the end of the array), go to ERR with no access.
    - When beat reaches total, go to IDLE (READYOUT=1). The last beat therefore reports READYOUT=1 in the following cycle.
  - TRANS=BUSY: hold; no access, no counter change.
  - TRANS=IDLE or SELX=0: abort the burst and go to IDLE; the remaining beats are dropped.
  - TRANS=NONSEQ with SELX=1: abort the current burst and treat the request as a new IDLE acceptance in the same edge.
- ERR:
  - One cycle with RESP=1, READYOUT=1; then unconditional return to IDLE.
  - TRANS is ignored while in ERR.
- The beat counter is 4 bits; next_addr is 32 bits and wrap-around above 2^32 is irrelevant because of the range check.

Test Plan:
- Reset: hold RSTN=0 for 2 cycles, release -> READYOUT=1, RESP=0, READ_DATA=0.
- SINGLE word: write 0xDEADBEEF to 0x10, then SINGLE read of 0x10 -> READ_DATA=0xDEADBEEF one cycle after accept; READYOUT stays 1.
- INCR4 word write at 0x20 with data 1,2,3,4, then INCR4 read -> READYOUT=0 for 3 cycles then 1; reads return 1,2,3,4 from 0x20,0x24,0x28,0x2C.
- WRAP4 word read at 0x38 -> address sequence 0x38,0x3C,0x30,0x34.
- Byte write 0xAA to 0x41, then word read of 0x40 -> lane 1 holds 0xAA and the other lanes are unchanged.
- Errors:
  - Word access at 0x02 -> RESP=1 for exactly one cycle, no write.
  - INCR8 at 0xF0 -> beats at 0xF0-0xFC complete, the 5th beat (0x100) gives RESP=1.
  - TRANS=IDLE mid-INCR4 -> READYOUT=1 the next cycle and the remaining words are unwritten.
